// File: rtl/tlc_signal_monitor.sv
// Traffic-light signal monitor: decodes light codes into lamp drive,
// checks the sequence and latches a flashing-red fault on any violation.
module tlc_signal_monitor #(
    parameter int MIN_YELLOW = 4,
    parameter int MIN_ALLRED = 2,
    parameter int BLINK_HALF = 8,
    parameter int CNT_W      = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] highwaySignal,
    input  logic [1:0] farmSignal,
    output logic [2:0] hwLamp,
    output logic [2:0] farmLamp,
    output logic       Fault,
    output logic [2:0] FaultCode
);

    typedef enum logic {MONITOR, FAULT} state_t;

    localparam logic [1:0] C_G = 2'b00;
    localparam logic [1:0] C_Y = 2'b01;
    localparam logic [1:0] C_R = 2'b10;
    localparam logic [1:0] C_X = 2'b11;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_OFF = 3'b000;

    localparam logic [CNT_W-1:0] MIN_Y  = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MIN_AR = CNT_W'(MIN_ALLRED);
    localparam logic [CNT_W-1:0] B_HALF = CNT_W'(BLINK_HALF);
    localparam logic [CNT_W-1:0] B_LAST = CNT_W'(2 * BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO   = '0;

    state_t           state, stateNxt;
    logic [1:0]       hwPrev, hwPrevNxt;
    logic [1:0]       farmPrev, farmPrevNxt;
    logic [CNT_W-1:0] hwYel, hwYelNxt;
    logic [CNT_W-1:0] farmYel, farmYelNxt;
    logic [CNT_W-1:0] allRed, allRedNxt;
    logic [CNT_W-1:0] blink, blinkNxt;
    logic [2:0]       hwLampNxt, farmLampNxt;
    logic             faultNxt;
    logic [2:0]       codeNxt;
    logic [2:0]       vioCode;

    logic invalid, conflict, badTrans, shortYel, shortRed;

    function automatic logic [2:0] decode(input logic [1:0] c);
        unique case (c)
            C_G:     decode = 3'b001;
            C_Y:     decode = 3'b010;
            default: decode = 3'b100;
        endcase
    endfunction

    function automatic logic illegal(input logic [1:0] p,
                                     input logic [1:0] c);
        illegal = (p == C_G && c == C_R)
               || (p == C_R && c == C_Y)
               || (p == C_Y && c == C_G);
    endfunction

    function automatic logic [CNT_W-1:0] satInc(
        input logic [CNT_W-1:0] v,
        input logic [CNT_W-1:0] lim
    );
        satInc = (v >= lim) ? v : v + ONE;
    endfunction

    assign invalid  = (highwaySignal == C_X) || (farmSignal == C_X);
    assign conflict = (highwaySignal != C_R) && (farmSignal != C_R);
    assign badTrans = illegal(hwPrev, highwaySignal)
                   || illegal(farmPrev, farmSignal);
    assign shortYel =
        (hwPrev == C_Y && highwaySignal == C_R && hwYel < MIN_Y)
     || (farmPrev == C_Y && farmSignal == C_R && farmYel < MIN_Y);
    assign shortRed =
        (hwPrev == C_R && highwaySignal == C_G && allRed < MIN_AR)
     || (farmPrev == C_R && farmSignal == C_G && allRed < MIN_AR);

    // Lowest code wins when several checks fire together
    always_comb begin
        vioCode = 3'd0;
        priority case (1'b1)
            invalid:  vioCode = 3'd1;
            conflict: vioCode = 3'd2;
            badTrans: vioCode = 3'd3;
            shortYel: vioCode = 3'd4;
            shortRed: vioCode = 3'd5;
            default:  vioCode = 3'd0;
        endcase
    end

    always_comb begin
        stateNxt    = state;
        hwPrevNxt   = hwPrev;
        farmPrevNxt = farmPrev;
        hwYelNxt    = hwYel;
        farmYelNxt  = farmYel;
        allRedNxt   = allRed;
        blinkNxt    = blink;
        hwLampNxt   = hwLamp;
        farmLampNxt = farmLamp;
        faultNxt    = Fault;
        codeNxt     = FaultCode;
        unique case (state)
            MONITOR: begin
                if (vioCode != 3'd0) begin
                    stateNxt    = FAULT;
                    faultNxt    = 1'b1;
                    codeNxt     = vioCode;
                    blinkNxt    = ZERO;
                    hwLampNxt   = L_RED;
                    farmLampNxt = L_RED;
                end else begin
                    hwLampNxt   = decode(highwaySignal);
                    farmLampNxt = decode(farmSignal);
                    hwPrevNxt   = highwaySignal;
                    farmPrevNxt = farmSignal;
                    hwYelNxt    = (highwaySignal == C_Y)
                                ? satInc(hwYel, MIN_Y) : ZERO;
                    farmYelNxt  = (farmSignal == C_Y)
                                ? satInc(farmYel, MIN_Y) : ZERO;
                    allRedNxt   = (highwaySignal == C_R
                                && farmSignal == C_R)
                                ? satInc(allRed, MIN_AR) : ZERO;
                end
            end
            FAULT: begin
                blinkNxt    = (blink == B_LAST) ? ZERO : blink + ONE;
                hwLampNxt   = (blinkNxt < B_HALF) ? L_RED : L_OFF;
                farmLampNxt = hwLampNxt;
            end
            default: stateNxt = MONITOR;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= MONITOR;
            hwPrev    <= C_R;
            farmPrev  <= C_R;
            hwYel     <= ZERO;
            farmYel   <= ZERO;
            allRed    <= MIN_AR;
            blink     <= ZERO;
            hwLamp    <= L_RED;
            farmLamp  <= L_RED;
            Fault     <= 1'b0;
            FaultCode <= 3'd0;
        end else begin
            state     <= stateNxt;
            hwPrev    <= hwPrevNxt;
            farmPrev  <= farmPrevNxt;
            hwYel     <= hwYelNxt;
            farmYel   <= farmYelNxt;
            allRed    <= allRedNxt;
            blink     <= blinkNxt;
            hwLamp    <= hwLampNxt;
            farmLamp  <= farmLampNxt;
            Fault     <= faultNxt;
            FaultCode <= codeNxt;
        end
    end

endmodule

// File: tb/tb_tlc_signal_monitor.sv
// Bench for tlc_signal_monitor: scoreboarded reference model
// plus directed checks of lamp timing, fault codes and flashing.
module tb_tlc_signal_monitor;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [1:0] highwaySignal;
    logic [1:0] farmSignal;
    logic [2:0] hwLamp;
    logic [2:0] farmLamp;
    logic       Fault;
    logic [2:0] FaultCode;

    int total = 0;
    int bad   = 0;

    logic [9:0] sb[$];

    // reference model state
    logic       mSt;
    logic [1:0] mHp, mFp;
    int         mHy, mFy, mAr, mBl;
    logic [2:0] mHl, mFl, mC;
    logic       mF;

    tlc_signal_monitor dut (
        .Clk(Clk),
        .Rst(Rst),
        .highwaySignal(highwaySignal),
        .farmSignal(farmSignal),
        .hwLamp(hwLamp),
        .farmLamp(farmLamp),
        .Fault(Fault),
        .FaultCode(FaultCode)
    );

    always #5 Clk = ~Clk;

    function automatic logic [2:0] lampOf(input logic [1:0] c);
        if (c == G) return 3'b001;
        if (c == Y) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic bad_tr(input logic [1:0] p,
                                    input logic [1:0] c);
        return (p == G && c == R) || (p == R && c == Y)
            || (p == Y && c == G);
    endfunction

    task automatic mdl(input logic r, input logic [1:0] h,
                       input logic [1:0] f);
        logic [2:0] c;
        if (r) begin
            mSt = 0; mHp = R; mFp = R; mHy = 0; mFy = 0;
            mAr = 2; mBl = 0; mHl = 3'b100; mFl = 3'b100;
            mF = 0; mC = 0;
        end else if (mSt == 0) begin
            c = 0;
            if (h == X || f == X) c = 1;
            else if (h != R && f != R) c = 2;
            else if (bad_tr(mHp, h) || bad_tr(mFp, f)) c = 3;
            else if ((mHp == Y && h == R && mHy < 4)
                  || (mFp == Y && f == R && mFy < 4)) c = 4;
            else if ((mHp == R && h == G && mAr < 2)
                  || (mFp == R && f == G && mAr < 2)) c = 5;
            if (c != 0) begin
                mSt = 1; mF = 1; mC = c; mBl = 0;
                mHl = 3'b100; mFl = 3'b100;
            end else begin
                mHl = lampOf(h); mFl = lampOf(f);
                mHy = (h == Y) ? ((mHy < 4) ? mHy + 1 : 4) : 0;
                mFy = (f == Y) ? ((mFy < 4) ? mFy + 1 : 4) : 0;
                mAr = (h == R && f == R)
                    ? ((mAr < 2) ? mAr + 1 : 2) : 0;
                mHp = h; mFp = f;
            end
        end else begin
            mBl = (mBl == 15) ? 0 : mBl + 1;
            mHl = (mBl < 8) ? 3'b100 : 3'b000;
            mFl = mHl;
        end
    endtask

    task automatic chk(input string tag, input logic [9:0] obs,
                       input logic [9:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] h,
                        input logic [1:0] f);
        logic [9:0] got;
        logic [9:0] exp;
        Rst = r; highwaySignal = h; farmSignal = f;
        mdl(r, h, f);
        sb.push_back({mHl, mFl, mF, mC});
        @(posedge Clk);
        #1;
        got = {hwLamp, farmLamp, Fault, FaultCode};
        exp = sb.pop_front();
        chk("scoreboard", got, exp);
        Rst = 1'b0;
    endtask

    task automatic run(input int n, input logic [1:0] h,
                       input logic [1:0] f);
        repeat (n) step(1'b0, h, f);
    endtask

    task automatic rst1();
        step(1'b1, R, R);
    endtask

    initial begin
        Rst = 1'b1; highwaySignal = R; farmSignal = R;
        repeat (2) @(posedge Clk);
        #1;

        // 1: legal full cycle
        rst1();
        chk("reset", {hwLamp, farmLamp, Fault, FaultCode},
            10'b100_100_0_000);
        step(1'b0, G, R);
        chk("t1_hw_green", {7'd0, hwLamp}, 10'b001);
        run(9, G, R);
        step(1'b0, Y, R);
        chk("t1_hw_yellow", {7'd0, hwLamp}, 10'b010);
        run(3, Y, R);
        step(1'b0, R, R);
        chk("t1_hw_red", {7'd0, hwLamp}, 10'b100);
        step(1'b0, R, R);
        run(10, R, G);
        chk("t1_farm_green", {7'd0, farmLamp}, 10'b001);
        run(4, R, Y);
        run(2, R, R);
        chk("t1_nofault", {6'd0, Fault, FaultCode}, 10'd0);

        // 2: invalid outranks conflict, flash pattern
        rst1();
        run(1, G, R);
        run(2, Y, R);
        step(1'b0, X, G);
        chk("t2_code1", {6'd0, Fault, FaultCode}, 10'b1_001);
        chk("t2_entry_red", {4'd0, hwLamp, farmLamp}, 10'b100_100);
        for (int i = 0; i < 17; i++) begin
            step(1'b0, G, R);
            chk("t2_flash", {7'd0, hwLamp},
                (i < 7 || i >= 15) ? 10'b100 : 10'b000);
        end

        // 3: conflict and illegal transitions
        rst1();
        run(3, G, R);
        step(1'b0, G, G);
        chk("t3_conflict", {7'd0, FaultCode}, 10'd2);
        rst1();
        run(2, G, R);
        step(1'b0, R, R);
        chk("t3_g_to_r", {7'd0, FaultCode}, 10'd3);
        rst1();
        run(2, R, R);
        step(1'b0, Y, R);
        chk("t3_r_to_y", {7'd0, FaultCode}, 10'd3);

        // 4: yellow duration boundary
        rst1();
        run(2, G, R);
        run(3, Y, R);
        step(1'b0, R, R);
        chk("t4_short_y", {7'd0, FaultCode}, 10'd4);
        rst1();
        run(2, G, R);
        run(4, Y, R);
        run(3, R, R);
        chk("t4_min_y_ok", {6'd0, Fault, FaultCode}, 10'd0);

        // 5: all-red duration boundary
        rst1();
        run(2, G, R);
        run(4, Y, R);
        run(1, R, R);
        step(1'b0, R, G);
        chk("t5_short_ar", {7'd0, FaultCode}, 10'd5);
        rst1();
        run(2, G, R);
        run(4, Y, R);
        run(2, R, R);
        step(1'b0, R, G);
        chk("t5_min_ar_ok", {6'd0, Fault, FaultCode}, 10'd0);
        rst1();
        step(1'b0, R, G);
        chk("t5_after_rst", {4'd0, farmLamp, Fault, FaultCode},
            10'b001_0_000);

        // 6: fault is sticky until reset
        rst1();
        run(1, G, R);
        step(1'b0, X, R);
        step(1'b0, G, R);
        step(1'b0, X, X);
        run(3, G, G);
        chk("t6_code_held", {7'd0, FaultCode}, 10'd1);
        chk("t6_flash_on", {4'd0, hwLamp, farmLamp}, 10'b100_100);
        rst1();
        chk("t6_reset", {hwLamp, farmLamp, Fault, FaultCode},
            10'b100_100_0_000);
        step(1'b0, G, R);
        chk("t6_resume", {hwLamp, farmLamp, Fault, FaultCode},
            10'b001_100_0_000);
        run(2, G, R);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
